// File: rtl/stream_upsizer_pkg.sv
// Shared width, keep-mask and lane-ordering helpers for the stream_upsizer
// narrow-to-wide packer.
package stream_upsizer_pkg;

    localparam int MAX_RATIO = 64;

    function automatic int lane_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Beat-order mask with beats 0..idx set, clipped to the lane count;
    // idx = -1 yields an empty mask.
    function automatic logic [MAX_RATIO-1:0] keep_upto(input int idx, input int ratio);
        logic [MAX_RATIO-1:0] upto;
        logic [MAX_RATIO-1:0] lanes;
        upto  = (MAX_RATIO'(1) << (idx + 1)) - MAX_RATIO'(1);
        lanes = (MAX_RATIO'(1) << ratio) - MAX_RATIO'(1);
        return upto & lanes;
    endfunction

    // Physical lane for beat number idx; the mapping is its own inverse.
    function automatic int lane_pos(input int idx, input bit lsb_first, input int ratio);
        return lsb_first ? idx : (ratio - 1 - idx);
    endfunction

endpackage

// File: rtl/stream_upsizer_out_reg.sv
// Output holding register of the upsizer: one wide word with keep/last and
// the valid/ready handshake toward the wide consumer.
module stream_upsizer_out_reg #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DATA_RATIO = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic [T_DATA_WIDTH-1:0] data_i [T_DATA_RATIO],
    input  logic [T_DATA_RATIO-1:0] keep_i,
    input  logic                    last_i,
    input  logic                    m_ready_i,
    output logic                    slot_free_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO],
    output logic [T_DATA_RATIO-1:0] m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o
);

    logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO];
    logic [T_DATA_WIDTH-1:0] data_d [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] keep_q, keep_d;
    logic                    last_q, last_d;
    logic                    valid_q, valid_d;

    // A load only happens when the slot is free, so it may overwrite a word
    // that is leaving in this same cycle.
    assign slot_free_o = !valid_q || m_ready_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            keep_d  = keep_i;
            last_d  = last_i;
            valid_d = 1'b1;
        end else if (m_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data array is reset because the output word is architecturally visible.
            data_q  <= '{default: '0};
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign m_data_o  = data_q;
    assign m_keep_o  = keep_q;
    assign m_last_o  = last_q;
    assign m_valid_o = valid_q;

endmodule

// File: rtl/stream_upsizer.sv
// Narrow-to-wide stream packer: gathers T_DATA_RATIO input beats into one
// output word with a lane keep mask, early close on last and idle flush.
module stream_upsizer
    import stream_upsizer_pkg::*;
#(
    parameter int T_DATA_WIDTH  = 8,
    parameter int T_DATA_RATIO  = 4,
    parameter int LSB_FIRST     = 1,
    parameter int FLUSH_TIMEOUT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO],
    output logic [T_DATA_RATIO-1:0] m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int IW = lane_idx_w(T_DATA_RATIO);
    localparam int CW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(T_DATA_RATIO - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FLUSH_TIMEOUT);

    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [T_DATA_WIDTH-1:0] acc_data_q [T_DATA_RATIO];
    logic [T_DATA_WIDTH-1:0] acc_data_d [T_DATA_RATIO];
    logic [T_DATA_WIDTH-1:0] merged     [T_DATA_RATIO];
    logic [T_DATA_WIDTH-1:0] load_data  [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] upto_close, upto_flush, keep_close, keep_flush, load_keep;
    logic [IW-1:0]           lane_sel;
    logic                    slot_free, accept, close, fire, load, load_last;

    assign s_ready_o = rst_n && slot_free;
    assign accept    = s_valid_i && s_ready_o;
    assign close     = accept && (idx_q == IDX_LAST || s_last_i);
    assign fire      = (FLUSH_TIMEOUT > 0) && (idx_q != '0) && !accept
                       && (cnt_q == CNT_MAX) && slot_free;

    assign lane_sel   = IW'(lane_pos(int'(idx_q), LSB_FIRST != 0, T_DATA_RATIO));
    assign upto_close = T_DATA_RATIO'(keep_upto(int'(idx_q), T_DATA_RATIO));
    assign upto_flush = T_DATA_RATIO'(keep_upto(int'(idx_q) - 1, T_DATA_RATIO));

    // Keep masks are built in beat order, then mapped onto physical lanes.
    for (genvar g = 0; g < T_DATA_RATIO; g++) begin : g_keep
        assign keep_close[g] = upto_close[lane_pos(g, LSB_FIRST != 0, T_DATA_RATIO)];
        assign keep_flush[g] = upto_flush[lane_pos(g, LSB_FIRST != 0, T_DATA_RATIO)];
    end

    always_comb begin
        merged           = acc_data_q;
        merged[lane_sel] = s_data_i;
    end

    always_comb begin
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        acc_data_d = acc_data_q;
        load       = 1'b0;
        load_data  = acc_data_q;
        load_keep  = keep_flush;
        load_last  = 1'b0;
        if (accept) begin
            cnt_d = '0;
            if (close) begin
                load       = 1'b1;
                load_data  = merged;
                load_keep  = keep_close;
                load_last  = s_last_i;
                acc_data_d = '{default: '0};
                idx_d      = '0;
            end else begin
                acc_data_d = merged;
                idx_d      = idx_q + 1'b1;
            end
        end else if (fire) begin
            load       = 1'b1;
            acc_data_d = '{default: '0};
            idx_d      = '0;
            cnt_d      = '0;
        end else if (idx_q != '0 && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            cnt_q      <= '0;
            acc_data_q <= '{default: '0};
        end else begin
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            acc_data_q <= acc_data_d;
        end
    end

    stream_upsizer_out_reg #(
        .T_DATA_WIDTH (T_DATA_WIDTH),
        .T_DATA_RATIO (T_DATA_RATIO)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .data_i      (load_data),
        .keep_i      (load_keep),
        .last_i      (load_last),
        .m_ready_i   (m_ready_i),
        .slot_free_o (slot_free),
        .m_data_o    (m_data_o),
        .m_keep_o    (m_keep_o),
        .m_last_o    (m_last_o),
        .m_valid_o   (m_valid_o)
    );

endmodule

// File: tb/tb_stream_upsizer.sv
// Bench for stream_upsizer: an LSB-first instance with flush timeout 5 and an
// MSB-first instance without timeout share one stimulus; each has its own model.
module tb_stream_upsizer;

    localparam int W = 8;
    localparam int R = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] s_data = '0;
    logic         s_last = 1'b0;
    logic         s_valid = 1'b0;
    logic         m_ready = 1'b1;

    logic [W-1:0] a_data [R];
    logic [R-1:0] a_keep;
    logic         a_last, a_valid, a_sready;
    logic [W-1:0] b_data [R];
    logic [R-1:0] b_keep;
    logic         b_last, b_valid, b_sready;

    int checks = 0;
    int errors = 0;

    stream_upsizer #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R), .LSB_FIRST(1), .FLUSH_TIMEOUT(5)) u_a (
        .clk(clk), .rst_n(rst_n), .s_data_i(s_data), .s_last_i(s_last), .s_valid_i(s_valid),
        .s_ready_o(a_sready), .m_data_o(a_data), .m_keep_o(a_keep), .m_last_o(a_last),
        .m_valid_o(a_valid), .m_ready_i(m_ready));

    stream_upsizer #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R), .LSB_FIRST(0), .FLUSH_TIMEOUT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .s_data_i(s_data), .s_last_i(s_last), .s_valid_i(s_valid),
        .s_ready_o(b_sready), .m_data_o(b_data), .m_keep_o(b_keep), .m_last_o(b_last),
        .m_valid_o(b_valid), .m_ready_i(m_ready));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [R*W-1:0] pack(input logic [W-1:0] l [R]);
        logic [R*W-1:0] v;
        for (int i = 0; i < R; i++) v[i*W +: W] = l[i];
        return v;
    endfunction

    // Reference model: pending beats plus an output slot, per instance.
    int             to_cfg  [2] = '{5, 0};
    bit             lsb_cfg [2] = '{1'b1, 1'b0};
    logic           mv [2];
    logic [R*W-1:0] md [2];
    logic [R-1:0]   mk [2];
    logic           ml [2];
    logic [W-1:0]   pd [2][R];
    int             pn [2];
    int             idle [2];

    task automatic emit(input int i, input logic last);
        md[i] = '0;
        mk[i] = '0;
        for (int j = 0; j < pn[i]; j++) begin
            int p;
            p = lsb_cfg[i] ? j : R - 1 - j;
            md[i][p*W +: W] = pd[i][j];
            mk[i][p] = 1'b1;
        end
        ml[i]   = last;
        mv[i]   = 1'b1;
        pn[i]   = 0;
        idle[i] = 0;
    endtask

    task automatic model_cycle(input int i, input logic [R*W-1:0] od, input logic [R-1:0] ok,
                               input logic ol, input logic ov, input logic osr);
        string n;
        logic  sf;
        n = (i == 0) ? "a" : "b";
        if (!rst_n) begin
            mv[i] = 1'b0; md[i] = '0; mk[i] = '0; ml[i] = 1'b0; pn[i] = 0; idle[i] = 0;
            check({n, "_rst_valid"}, ov, 0);
            check({n, "_rst_keep"}, ok, 0);
            check({n, "_rst_last"}, ol, 0);
            check({n, "_rst_data"}, od, 0);
            check({n, "_rst_sready"}, osr, 0);
            return;
        end
        sf = !mv[i] || m_ready;
        check({n, "_valid"}, ov, mv[i]);
        check({n, "_sready"}, osr, sf);
        if (mv[i]) begin
            check({n, "_data"}, od, md[i]);
            check({n, "_keep"}, ok, mk[i]);
            check({n, "_last"}, ol, ml[i]);
        end
        if (mv[i] && m_ready) mv[i] = 1'b0;
        if (s_valid && sf) begin
            pd[i][pn[i]] = s_data;
            pn[i]++;
            idle[i] = 0;
            if (pn[i] == R || s_last) emit(i, s_last);
        end else if (pn[i] > 0) begin
            if (to_cfg[i] > 0 && idle[i] >= to_cfg[i] && sf) emit(i, 1'b0);
            else if (idle[i] < to_cfg[i]) idle[i]++;
        end
    endtask

    always @(negedge clk) begin
        model_cycle(0, pack(a_data), a_keep, a_last, a_valid, a_sready);
        model_cycle(1, pack(b_data), b_keep, b_last, b_valid, b_sready);
    end

    task automatic beat(input logic [W-1:0] d, input logic l);
        bit ok;
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        do begin
            @(negedge clk);
            ok = a_sready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("beat_accept", ok, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_a_valid(output int n);
        n = 0;
        while (!a_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(1);

        // Full word, both lane orders.
        beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 0);
        check("full_valid", a_valid, 1);
        check("full_data_a", pack(a_data), 32'h44332211);
        check("full_keep_a", a_keep, 4'b1111);
        check("full_last_a", a_last, 0);
        check("full_data_b", pack(b_data), 32'h11223344);
        idle_cycles(1);
        check("full_one_cycle", a_valid, 0);

        // Short packet closed by last on the second beat.
        beat(8'hA1, 0); beat(8'hA2, 1);
        check("short_data_a", pack(a_data), 32'h0000A2A1);
        check("short_keep_a", a_keep, 4'b0011);
        check("short_last_a", a_last, 1);
        check("short_data_b", pack(b_data), 32'hA1A20000);
        check("short_keep_b", b_keep, 4'b1100);
        idle_cycles(2);

        // Backpressure: the first word stalls, the second follows intact.
        m_ready = 1'b0;
        beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0); beat(8'h04, 0);
        s_valid = 1'b1;
        s_data  = 8'h05;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("bp_sready", a_sready, 0);
        check("bp_hold_valid", a_valid, 1);
        check("bp_hold_data", pack(a_data), 32'h04030201);
        m_ready = 1'b1;
        beat(8'h05, 0); beat(8'h06, 0); beat(8'h07, 0); beat(8'h08, 0);
        check("bp_word2", pack(a_data), 32'h08070605);
        idle_cycles(2);

        // Idle flush after five idle cycles, then a late beat that cancels it.
        beat(8'h5A, 0);
        wait_a_valid(lat);
        check("flush_latency", lat, 6);
        check("flush_data", pack(a_data), 32'h0000005A);
        check("flush_keep", a_keep, 4'b0001);
        check("flush_last", a_last, 0);
        idle_cycles(2);
        beat(8'h5B, 0);
        idle_cycles(3);
        beat(8'h5C, 0);
        wait_a_valid(lat);
        check("cancel_latency", lat, 6);
        check("cancel_keep", a_keep, 4'b0011);
        check("cancel_data", pack(a_data), 32'h00005C5B);
        idle_cycles(3);

        // Reset in the middle of a word.
        beat(8'h01, 0); beat(8'h02, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", a_valid, 0);
        check("midrst_sready", a_sready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0); beat(8'h04, 0);
        check("postrst_data_a", pack(a_data), 32'h04030201);
        check("postrst_keep_a", a_keep, 4'b1111);
        check("postrst_data_b", pack(b_data), 32'h01020304);
        idle_cycles(1);

        // Last on the first beat gives a one-lane word.
        beat(8'h77, 1);
        check("single_data_a", pack(a_data), 32'h00000077);
        check("single_keep_a", a_keep, 4'b0001);
        check("single_last_a", a_last, 1);
        check("single_keep_b", b_keep, 4'b1000);
        idle_cycles(2);

        // Random traffic against the models, with stalls, long gaps and one reset.
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_data  = 8'($urandom);
            s_last  = ($urandom_range(0, 5) == 0);
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) begin
                s_valid = 1'b0;
                m_ready = 1'($urandom_range(0, 1));
                repeat (9) @(posedge clk);
                #1;
            end
            if (c == 1500) rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        idle_cycles(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
